// File: rtl/parser_input_arbiter.sv
// Packet-atomic round-robin arbiter in front of the sequence parser.
// Holds one port for a whole packet and checks beat count vs header length.
module parser_input_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ID_W      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   portEnable,
  input  logic [32*NUM_PORTS-1:0] dataIn,
  input  logic [NUM_PORTS-1:0]   dataIn_val,
  input  logic [NUM_PORTS-1:0]   dataIn_last,
  output logic [NUM_PORTS-1:0]   dataIn_ready,
  output logic [31:0]            dataOut,
  output logic                   dataOut_val,
  output logic                   dataOut_last,
  input  logic                   dataOut_ready,
  output logic                   grantValid,
  output logic [ID_W-1:0]        grantId,
  output logic                   lenErr,
  output logic [15:0]            pktCount
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FWD  = 1'b1;

  logic [0:0]      r_state;
  logic [ID_W-1:0] r_rrPtr;
  logic [ID_W-1:0] r_grantId;
  logic            r_grantValid;
  logic            r_lenErr;
  logic [15:0]     r_pktCount;
  logic [15:0]     r_beatCnt;
  logic [16:0]     r_expBeats;
  logic            r_lenShort;

  logic [NUM_PORTS-1:0] w_req;
  logic            w_found;
  logic [ID_W-1:0] w_win;
  int              w_idx;
  logic [31:0]     w_gData;
  logic            w_gVal;
  logic            w_gLast;
  logic            w_fwd;
  logic            w_hs;
  logic            w_hdr;
  logic            w_eop;
  logic [15:0]     w_len;
  logic [16:0]     w_expNew;
  logic            w_shortNew;
  logic [16:0]     w_expCur;
  logic            w_shortCur;
  logic [16:0]     w_total;

  // Round-robin search starting at the pointer, wrapping modulo NUM_PORTS
  always_comb begin
    w_req   = dataIn_val & portEnable;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = int'(r_rrPtr) + k;
      if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_gData = '0;
    w_gVal  = 1'b0;
    w_gLast = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ID_W'(i) == r_grantId) begin
        w_gData = dataIn[32*i +: 32];
        w_gVal  = dataIn_val[i];
        w_gLast = dataIn_last[i];
      end
    end
  end

  assign w_fwd        = (r_state == S_FWD);
  assign dataOut      = w_fwd ? w_gData : 32'd0;
  assign dataOut_val  = w_fwd & w_gVal;
  assign dataOut_last = w_fwd & w_gLast;

  always_comb begin
    dataIn_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      dataIn_ready[i] = w_fwd && dataOut_ready && (ID_W'(i) == r_grantId);
    end
  end

  assign w_hs       = dataOut_val & dataOut_ready;
  assign w_hdr      = w_hs && (r_beatCnt == 16'd0);
  assign w_eop      = w_hs & dataOut_last;
  assign w_len      = w_gData[31:16];
  assign w_expNew   = ({1'b0, w_len} + 17'd3) >> 2;
  assign w_shortNew = (w_len < 16'd8);
  // A single-beat packet checks against its own header, not the stale register
  assign w_expCur   = w_hdr ? w_expNew : r_expBeats;
  assign w_shortCur = w_hdr ? w_shortNew : r_lenShort;
  assign w_total    = {1'b0, r_beatCnt} + 17'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rrPtr      <= '0;
      r_grantId    <= '0;
      r_grantValid <= 1'b0;
      r_lenErr     <= 1'b0;
      r_pktCount   <= '0;
      r_beatCnt    <= '0;
      r_expBeats   <= '0;
      r_lenShort   <= 1'b0;
    end else begin
      r_lenErr <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_found) begin
          r_grantId    <= w_win;
          r_grantValid <= 1'b1;
          r_beatCnt    <= '0;
          r_state      <= S_FWD;
        end
      end else begin
        if (w_hdr) begin
          r_expBeats <= w_expNew;
          r_lenShort <= w_shortNew;
        end
        if (w_hs) r_beatCnt <= r_beatCnt + 16'd1;
        if (w_eop) begin
          r_lenErr     <= (w_total != w_expCur) || w_shortCur;
          r_state      <= S_IDLE;
          r_grantValid <= 1'b0;
          r_pktCount   <= r_pktCount + 16'd1;
          r_rrPtr      <= (r_grantId == ID_W'(NUM_PORTS - 1)) ?
                          '0 : r_grantId + ID_W'(1);
        end
      end
    end
  end

  assign grantValid = r_grantValid;
  assign grantId    = r_grantId;
  assign lenErr     = r_lenErr;
  assign pktCount   = r_pktCount;

endmodule

// File: tb/tb_parser_input_arbiter.sv
// Random traffic bench for parser_input_arbiter.
// Packet-level sources plus a grant/scoreboard model.
module tb_parser_input_arbiter;

  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   portEnable;
  logic [32*NP-1:0] dataIn;
  logic [NP-1:0]   dataIn_val;
  logic [NP-1:0]   dataIn_last;
  logic [NP-1:0]   dataIn_ready;
  logic [31:0]     dataOut;
  logic            dataOut_val;
  logic            dataOut_last;
  logic            dataOut_ready;
  logic            grantValid;
  logic [1:0]      grantId;
  logic            lenErr;
  logic [15:0]     pktCount;

  always #5 clk = ~clk;

  parser_input_arbiter #(.NUM_PORTS(NP), .ID_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .portEnable   (portEnable),
    .dataIn       (dataIn),
    .dataIn_val   (dataIn_val),
    .dataIn_last  (dataIn_last),
    .dataIn_ready (dataIn_ready),
    .dataOut      (dataOut),
    .dataOut_val  (dataOut_val),
    .dataOut_last (dataOut_last),
    .dataOut_ready(dataOut_ready),
    .grantValid   (grantValid),
    .grantId      (grantId),
    .lenErr       (lenErr),
    .pktCount     (pktCount)
  );

  logic [31:0] pk [NP][6];
  int          pn [NP];
  int          pi [NP];
  int          gap[NP];
  bit          act[NP];
  bit          perr[NP];

  bit          m_locked;
  int          m_g;
  int          m_rr;
  logic [15:0] m_pkt;
  bit          m_lenErr;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic gen_pkt(input int p);
    int n;
    int len;
    n = $urandom_range(1, 5);
    if ($urandom_range(0, 3) == 0) len = $urandom_range(0, 40);
    else len = (n - 1) * 4 + $urandom_range(1, 4);
    pn[p]   = n;
    pi[p]   = 0;
    act[p]  = 1'b1;
    perr[p] = (((len + 3) / 4) != n) || (len < 8);
    pk[p][0] = {len[15:0], 16'($urandom)};
    for (int b = 1; b < 6; b++) pk[p][b] = $urandom;
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_g      = 0;
    m_rr     = 0;
    m_pkt    = '0;
    m_lenErr = 1'b0;
    for (int p = 0; p < NP; p++) begin
      act[p] = 1'b0;
      gap[p] = 0;
    end
  endtask

  initial begin
    logic [NP-1:0] req;
    bit            hs;
    bit            rst_now;
    logic [31:0]   e_data;
    logic [NP-1:0] e_rdy;

    reset         = 1'b1;
    portEnable    = '1;
    dataIn        = '0;
    dataIn_val    = '1;
    dataIn_last   = '0;
    dataOut_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gv",   grantValid,   0);
    chk("rst_gid",  grantId,      0);
    chk("rst_err",  lenErr,       0);
    chk("rst_cnt",  pktCount,     0);
    chk("rst_oval", dataOut_val,  0);
    chk("rst_rdy",  dataIn_ready, 0);
    model_reset();
    @(posedge clk);
    #1;

    for (int c = 0; c < 3000; c++) begin
      rst_now = (c == 900) || (c == 1901);
      reset   = rst_now;
      for (int p = 0; p < NP; p++) begin
        if (!act[p]) begin
          if (gap[p] > 0) gap[p]--;
          else gen_pkt(p);
        end
        dataIn_val[p]  = act[p] && ($urandom_range(0, 4) != 0);
        dataIn_last[p] = act[p] && (pi[p] == pn[p] - 1);
        dataIn[32*p +: 32] = act[p] ? pk[p][pi[p]] : $urandom;
      end
      if ($urandom_range(0, 9) == 0)
        portEnable[$urandom_range(0, NP-1)] ^= 1'b1;
      dataOut_ready = ($urandom_range(0, 3) != 0);

      @(negedge clk);
      e_data = m_locked ? dataIn[32*m_g +: 32] : 32'd0;
      e_rdy  = (m_locked && dataOut_ready) ? NP'(1 << m_g) : '0;
      chk("gvalid", grantValid, m_locked);
      if (m_locked) chk("gid", grantId, m_g);
      chk("oval",  dataOut_val,  m_locked && dataIn_val[m_g]);
      chk("olast", dataOut_last, m_locked && dataIn_last[m_g]);
      chk("odata", dataOut,      e_data);
      chk("irdy",  dataIn_ready, e_rdy);
      chk("lenerr", lenErr,      m_lenErr);
      chk("pktcnt", pktCount,    m_pkt);
      req = dataIn_val & portEnable;
      hs  = m_locked && dataIn_val[m_g] && dataOut_ready;

      @(posedge clk);
      if (rst_now) begin
        model_reset();
      end else begin
        m_lenErr = 1'b0;
        if (!m_locked) begin
          for (int k = 0; k < NP; k++) begin
            if (!m_locked && req[(m_rr + k) % NP]) begin
              m_locked = 1'b1;
              m_g      = (m_rr + k) % NP;
            end
          end
        end else if (hs) begin
          pi[m_g]++;
          if (pi[m_g] == pn[m_g]) begin
            m_lenErr = perr[m_g];
            m_pkt    = m_pkt + 16'd1;
            m_rr     = (m_g + 1) % NP;
            m_locked = 1'b0;
            act[m_g] = 1'b0;
            gap[m_g] = $urandom_range(0, 2);
          end
        end
      end
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
